// File: rtl/pal_sweep_pkg.sv
// rtl/pal_sweep_pkg.sv - shared types for the PAL sweep driver
package pal_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_HOLD,
        ST_PUSH,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] in;
        logic [7:0] out;
        logic       last;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/pal_rec_fifo.sv
// rtl/pal_rec_fifo.sv - synchronous record FIFO, async active-high reset
module pal_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pal_sweep_driver.sv
// rtl/pal_sweep_driver.sv - steps an 8-bit vector range into a PAL and queues (input, output) records
module pal_sweep_driver
    import pal_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PAL_CLOCKS    = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] vec_first,
    input  logic [7:0] vec_last,
    output logic       busy,
    output logic       done,
    output logic [7:0] pal_i,
    output logic       pal_clk,
    input  logic [7:0] pal_o,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic [7:0] rec_in,
    output logic [7:0] rec_out,
    output logic       rec_last
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] PAL_LAST    = 4'((PAL_CLOCKS == 0) ? 0 : PAL_CLOCKS - 1);

    state_t     state_q, state_d;
    logic [7:0] cur_q, cur_d, last_q, last_d, sample_q, sample_d, cnt_q, cnt_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       busy_q, busy_d, done_q, done_d, pal_clk_q, pal_clk_d;
    logic       fifo_full, fifo_empty, fifo_push;
    rec_t       wrec, head;

    assign fifo_push = (state_q == ST_PUSH) && !fifo_full;
    assign wrec      = '{in: cur_q, out: sample_q, last: (cur_q == last_q)};

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        sample_d  = sample_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pal_clk_d = pal_clk_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = vec_first;
                    last_d  = vec_last;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    if (PAL_CLOCKS > 0) begin
                        pal_clk_d = 1'b1;
                        state_d   = ST_CLK_HI;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CLK_HI: begin
                pal_clk_d = 1'b0;
                state_d   = ST_CLK_LO;
            end
            ST_CLK_LO: begin
                if (pcnt_q == PAL_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    pcnt_d    = pcnt_q + 4'd1;
                    pal_clk_d = 1'b1;
                    state_d   = ST_CLK_HI;
                end
            end
            ST_HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    sample_d = pal_o;
                    cnt_d    = '0;
                    state_d  = ST_PUSH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PUSH: begin
                // A full FIFO parks here with pal_i and pal_clk frozen
                if (!fifo_full) begin
                    if (cur_q == last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + 8'd1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            sample_q  <= '0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pal_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pal_clk_q <= pal_clk_d;
        end
    end

    pal_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (wrec),
        .pop   (rec_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign pal_i     = cur_q;
    assign pal_clk   = pal_clk_q;
    assign rec_valid = !fifo_empty;
    assign rec_in    = head.in;
    assign rec_out   = head.out;
    assign rec_last  = head.last;

endmodule

// File: tb/tb_pal_sweep_driver.sv
// tb/tb_pal_sweep_driver.sv - randomized self-checking bench for pal_sweep_driver
module tb_pal_sweep_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] vec_first, vec_last;
    logic       start_a, rdy_a, busy_a, done_a, pal_clk_a, rv_a, rl_a;
    logic [7:0] pal_i_a, pal_o_a, ri_a, ro_a;
    logic       start_b, rdy_b, busy_b, done_b, pal_clk_b, rv_b, rl_b;
    logic [7:0] pal_i_b, pal_o_b, ri_b, ro_b;

    logic [7:0] mask = 8'h00;
    logic [7:0] pal_reg_a = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap_in[$];
    logic [7:0] cap_out[$];
    logic       cap_last[$];
    logic [7:0] exp_in[$];
    logic       exp_last[$];
    int         done_cnt, done_cyc, busy_rise_cyc, clk_toggles, timed_out;
    logic [7:0] snap_pal_i;
    logic       snap_pal_clk, snap_busy;

    always #5 clk = ~clk;

    // PAL under test: registered identity (XOR mask) for A, combinational for B
    always @(posedge pal_clk_a) pal_reg_a <= pal_i_a;
    assign pal_o_a = pal_reg_a ^ mask;
    assign pal_o_b = pal_i_b ^ mask;

    pal_sweep_driver dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec_first(vec_first), .vec_last(vec_last),
        .busy(busy_a), .done(done_a), .pal_i(pal_i_a), .pal_clk(pal_clk_a), .pal_o(pal_o_a),
        .rec_valid(rv_a), .rec_ready(rdy_a), .rec_in(ri_a), .rec_out(ro_a), .rec_last(rl_a)
    );

    pal_sweep_driver #(.PAL_CLOCKS(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec_first(vec_first), .vec_last(vec_last),
        .busy(busy_b), .done(done_b), .pal_i(pal_i_b), .pal_clk(pal_clk_b), .pal_o(pal_o_b),
        .rec_valid(rv_b), .rec_ready(rdy_b), .rec_in(ri_b), .rec_out(ro_b), .rec_last(rl_b)
    );

    task automatic build_expected(input logic [7:0] f, input logic [7:0] l);
        logic [7:0] v;
        exp_in.delete();
        exp_last.delete();
        v = f;
        for (int n = 0; n < 256; n++) begin
            exp_in.push_back(v);
            exp_last.push_back(v == l);
            if (v == l) break;
            v = v + 8'd1;
        end
    endtask

    task automatic run_sweep(input int dsel, input logic [7:0] f, input logic [7:0] l,
                             input int ready_pct, input int hold_until, input int inject_cyc,
                             input int max_cyc);
        int   cyc;
        logic prev_clk, r;
        logic s_busy, s_done, s_clk, s_valid, s_last;
        logic [7:0] s_pal_i, s_in, s_out;
        cap_in.delete();
        cap_out.delete();
        cap_last.delete();
        done_cnt = 0; done_cyc = -1; busy_rise_cyc = -1; clk_toggles = 0; timed_out = 0;
        @(negedge clk);
        vec_first = f;
        vec_last  = l;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        if (dsel == 0) start_a = 1'b1; else start_b = 1'b1;
        cyc = 0;
        prev_clk = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == inject_cyc) begin
                vec_first = 8'h80;
                vec_last  = 8'h90;
                if (dsel == 0) start_a = 1'b1; else start_b = 1'b1;
            end
            s_busy  = (dsel == 0) ? busy_a    : busy_b;
            s_done  = (dsel == 0) ? done_a    : done_b;
            s_clk   = (dsel == 0) ? pal_clk_a : pal_clk_b;
            s_valid = (dsel == 0) ? rv_a      : rv_b;
            s_last  = (dsel == 0) ? rl_a      : rl_b;
            s_pal_i = (dsel == 0) ? pal_i_a   : pal_i_b;
            s_in    = (dsel == 0) ? ri_a      : ri_b;
            s_out   = (dsel == 0) ? ro_a      : ro_b;
            if (s_busy && busy_rise_cyc < 0) busy_rise_cyc = cyc;
            if (s_clk !== prev_clk) clk_toggles++;
            prev_clk = s_clk;
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == hold_until - 1) begin
                snap_pal_i   = s_pal_i;
                snap_pal_clk = s_clk;
                snap_busy    = s_busy;
            end
            r = (cyc < hold_until) ? 1'b0 : ($urandom_range(1, 100) <= ready_pct);
            if (dsel == 0) rdy_a = r; else rdy_b = r;
            if (s_valid && r) begin
                cap_in.push_back(s_in);
                cap_out.push_back(s_out);
                cap_last.push_back(s_last);
            end
            if (done_cnt > 0 && !s_valid && !s_busy) break;
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
        end
        rdy_a = 1'b1;
        rdy_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        vec_first = 8'h00; vec_last = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, pal_clk_a, rv_a, rl_a, pal_i_a, ri_a, ro_a} !== 29'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", {busy_a, done_a, pal_clk_a, rv_a, rl_a, pal_i_a, ri_a, ro_a});
        end
        checks++;
        if ({busy_b, done_b, pal_clk_b, rv_b, rl_b, pal_i_b, ri_b, ro_b} !== 29'd0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", {busy_b, done_b, pal_clk_b, rv_b, rl_b, pal_i_b, ri_b, ro_b});
        end
        rst = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        mask = 8'h00;
        build_expected(8'h00, 8'hFF);
        run_sweep(0, 8'h00, 8'hFF, 100, 0, -1, 4000);
        checks++;
        if (timed_out != 0) begin failures++; $display("FAIL full_timeout got=%0d exp=0", timed_out); end
        checks++;
        if (cap_in.size() != 256) begin failures++; $display("FAIL full_count got=%0d exp=256", cap_in.size()); end
        for (int k = 0; k < exp_in.size(); k++) begin
            logic [16:0] got, exp;
            got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
            exp = {exp_in[k], exp_in[k], exp_last[k]};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL full_rec[%0d] got=%h exp=%h", k, got, exp); end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (done_cyc != 11 * 256 + 1) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, 11 * 256 + 1); end
    endtask

    task automatic test_wrap();
        mask = 8'($urandom);
        build_expected(8'hFE, 8'h01);
        run_sweep(0, 8'hFE, 8'h01, 50, 0, -1, 2000);
        checks++;
        if (timed_out != 0 || cap_in.size() != 4) begin
            failures++; $display("FAIL wrap_count got=%0d exp=4 timeout=%0d", cap_in.size(), timed_out);
        end
        for (int k = 0; k < exp_in.size(); k++) begin
            logic [16:0] got, exp;
            got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
            exp = {exp_in[k], exp_in[k] ^ mask, exp_last[k]};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL wrap_rec[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_back_pressure();
        mask = 8'($urandom);
        build_expected(8'h00, 8'h09);
        run_sweep(0, 8'h00, 8'h09, 100, 120, -1, 1000);
        checks++;
        if ({snap_pal_i, snap_pal_clk, snap_busy} !== {8'h04, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL bp_stall got pal_i=%h pal_clk=%b busy=%b exp pal_i=04 pal_clk=0 busy=1",
                     snap_pal_i, snap_pal_clk, snap_busy);
        end
        checks++;
        if (timed_out != 0 || cap_in.size() != 10) begin
            failures++; $display("FAIL bp_count got=%0d exp=10 timeout=%0d", cap_in.size(), timed_out);
        end
        for (int k = 0; k < exp_in.size(); k++) begin
            logic [16:0] got, exp;
            got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
            exp = {exp_in[k], exp_in[k] ^ mask, exp_last[k]};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL bp_rec[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_comb_observe();
        logic [16:0] got, exp;
        mask = 8'($urandom);
        run_sweep(1, 8'h5A, 8'h5A, 100, 0, -1, 200);
        checks++;
        if (clk_toggles != 0) begin failures++; $display("FAIL comb_pal_clk toggles=%0d exp=0", clk_toggles); end
        checks++;
        if (timed_out != 0 || cap_in.size() != 1) begin
            failures++; $display("FAIL comb_count got=%0d exp=1 timeout=%0d", cap_in.size(), timed_out);
        end
        got = (cap_in.size() > 0) ? {cap_in[0], cap_out[0], cap_last[0]} : 17'bx;
        exp = {8'h5A, 8'h5A ^ mask, 1'b1};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL comb_rec got=%h exp=%h", got, exp); end
        checks++;
        if (done_cyc - busy_rise_cyc != 9) begin
            failures++; $display("FAIL comb_latency got=%0d exp=9", done_cyc - busy_rise_cyc);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int found;
        mask = 8'($urandom);
        @(negedge clk);
        vec_first = 8'h00; vec_last = 8'h09;
        rdy_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0;
        for (int n = 0; n < 200; n++) begin
            if (pal_i_a == 8'h03 && pal_clk_a == 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL rmid_reach got=0 exp=1"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({pal_clk_a, pal_i_a, rv_a, busy_a} !== 11'd0) begin
            failures++;
            $display("FAIL rmid_async got pal_clk=%b pal_i=%h rec_valid=%b busy=%b exp all 0",
                     pal_clk_a, pal_i_a, rv_a, busy_a);
        end
        @(negedge clk);
        rst = 1'b0;
        rdy_a = 1'b1;
        build_expected(8'h20, 8'h22);
        run_sweep(0, 8'h20, 8'h22, 100, 0, -1, 500);
        checks++;
        if (timed_out != 0 || cap_in.size() != 3 || done_cnt != 1) begin
            failures++;
            $display("FAIL rmid_restart got count=%0d done=%0d timeout=%0d exp 3 1 0", cap_in.size(), done_cnt, timed_out);
        end
        for (int k = 0; k < exp_in.size(); k++) begin
            logic [16:0] got, exp;
            got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
            exp = {exp_in[k], exp_in[k] ^ mask, exp_last[k]};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL rmid_rec[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_start_while_busy();
        mask = 8'($urandom);
        build_expected(8'h10, 8'h14);
        run_sweep(0, 8'h10, 8'h14, 100, 0, 30, 600);
        checks++;
        if (timed_out != 0 || cap_in.size() != 5 || done_cnt != 1) begin
            failures++;
            $display("FAIL swb_count got count=%0d done=%0d timeout=%0d exp 5 1 0", cap_in.size(), done_cnt, timed_out);
        end
        for (int k = 0; k < exp_in.size(); k++) begin
            logic [16:0] got, exp;
            got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
            exp = {exp_in[k], exp_in[k] ^ mask, exp_last[k]};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL swb_rec[%0d] got=%h exp=%h", k, got, exp); end
        end
        // an accepted stray start would leave the FSM busy after the sweep
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL swb_idle got busy=%b exp=0", busy_a); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int         dsel, pct;
            logic [7:0] f, l;
            dsel = $urandom_range(0, 1);
            pct  = $urandom_range(20, 100);
            f    = 8'($urandom);
            l    = f + 8'($urandom_range(0, 15));
            mask = 8'($urandom);
            build_expected(f, l);
            run_sweep(dsel, f, l, pct, 0, -1, 3000);
            checks++;
            if (timed_out != 0 || cap_in.size() != exp_in.size() || done_cnt != 1) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d exp=%0d done=%0d timeout=%0d", it, cap_in.size(), exp_in.size(), done_cnt, timed_out);
            end
            for (int k = 0; k < exp_in.size(); k++) begin
                logic [16:0] got, exp;
                got = (k < cap_in.size()) ? {cap_in[k], cap_out[k], cap_last[k]} : 17'bx;
                exp = {exp_in[k], exp_in[k] ^ mask, exp_last[k]};
                checks++;
                if (got !== exp) begin failures++; $display("FAIL rand%0d_rec[%0d] got=%h exp=%h", it, k, got, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_wrap();
        test_back_pressure();
        test_comb_observe();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
